mctrl_req_queue: RTL and testbench

Request queue and sequencer sitting directly upstream of the DDR3 memory controller's CPU port. It buffers read and write requests from a traffic source in a FIFO and issues them one at a time with the controller's valid/ready protocol. It drives the controller's `i_cpu_*` inputs and consumes `o_cpu_data_rdy`, `o_cpu_rd_data` and `o_cpu_rd_data_valid`. Read data is returned to the source with its address, and a watchdog flags reads that are never answered.

---
 rtl/mctrl_req_queue.sv | 195 +++++++++++++++++++
 tb/tb_mctrl_req_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mctrl_req_queue.sv
// Request queue and sequencer feeding the DDR3 controller CPU port.
// Buffers source requests in a FIFO, issues them one at a time with a
// valid/ready handshake, returns read data with its address, and flags
// reads that never receive data.
module mctrl_req_queue #(
    parameter int unsigned ADDR_MCTRL = 27,
    parameter int unsigned DQ_BITS    = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                      i_cpu_ck,
    input  logic                      i_cpu_reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_cmd,
    input  logic [ADDR_MCTRL-1:0]     req_addr,
    input  logic [8*DQ_BITS-1:0]      req_wr_data,
    output logic                      mc_valid,
    output logic                      mc_enable,
    output logic                      mc_cmd,
    output logic [ADDR_MCTRL-1:0]     mc_addr,
    output logic [8*DQ_BITS-1:0]      mc_wr_data,
    input  logic                      mc_data_rdy,
    input  logic [8*DQ_BITS-1:0]      mc_rd_data,
    input  logic                      mc_rd_data_valid,
    output logic                      rsp_valid,
    output logic [ADDR_MCTRL-1:0]     rsp_addr,
    output logic [8*DQ_BITS-1:0]      rsp_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned DW = 8 * DQ_BITS;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic                  cmd;
        logic [ADDR_MCTRL-1:0] addr;
        logic [DW-1:0]         wr_data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLD    = 2'd2,
        WAIT_RD = 2'd3
    } state_t;

    entry_t                r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WW-1:0]         r_wd;
    logic [WW-1:0]         w_wd_nxt;

    logic                  r_mc_valid;
    logic                  r_mc_enable;
    logic                  r_mc_cmd;
    logic [ADDR_MCTRL-1:0] r_mc_addr;
    logic [DW-1:0]         r_mc_wr_data;
    logic                  r_rsp_valid;
    logic [ADDR_MCTRL-1:0] r_rsp_addr;
    logic [DW-1:0]         r_rsp_data;
    logic                  r_busy;
    logic                  r_timeout_err;

    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_fire;
    logic                  w_timeout;
    entry_t                w_head;

    // Accept whenever the registered occupancy shows a free slot.
    assign w_ready = (r_count != CW'(DEPTH));
    assign w_push  = req_valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge i_cpu_ck) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{cmd: req_cmd, addr: req_addr, wr_data: req_wr_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
        if (i_cpu_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer next-state, pop decision and watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_pop       = 1'b0;
        w_rsp_fire  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) && mc_data_rdy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_wd_nxt    = '0;
                w_state_nxt = r_mc_cmd ? HOLD : WAIT_RD;
            end
            HOLD: begin
                w_state_nxt = IDLE;
            end
            WAIT_RD: begin
                if (mc_rd_data_valid) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wd == WW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wd_nxt    = r_wd + WW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, controller-side and response-side registers.
    always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
        if (i_cpu_reset) begin
            r_state       <= IDLE;
            r_wd          <= '0;
            r_mc_valid    <= 1'b0;
            r_mc_enable   <= 1'b0;
            r_mc_cmd      <= 1'b0;
            r_mc_addr     <= '0;
            r_mc_wr_data  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_addr    <= '0;
            r_rsp_data    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wd          <= w_wd_nxt;
            r_mc_valid    <= (w_state_nxt == ISSUE);
            r_mc_enable   <= 1'b1;
            r_busy        <= (w_state_nxt != IDLE);
            r_rsp_valid   <= w_rsp_fire;
            r_timeout_err <= r_timeout_err | w_timeout;
            if (w_pop) begin
                r_mc_cmd     <= w_head.cmd;
                r_mc_addr    <= w_head.addr;
                r_mc_wr_data <= w_head.wr_data;
            end
            if (w_rsp_fire) begin
                r_rsp_addr <= r_mc_addr;
                r_rsp_data <= mc_rd_data;
            end
        end
    end

    assign req_ready   = w_ready;
    assign mc_valid    = r_mc_valid;
    assign mc_enable   = r_mc_enable;
    assign mc_cmd      = r_mc_cmd;
    assign mc_addr     = r_mc_addr;
    assign mc_wr_data  = r_mc_wr_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_data    = r_rsp_data;
    assign fifo_count  = r_count;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mctrl_req_queue.sv
// Directed bench for mctrl_req_queue: reset, single write/read, full FIFO,
// read timeout and reset while a read is outstanding.
module tb_mctrl_req_queue;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_cmd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wr_data = '0;
    logic          mc_valid;
    logic          mc_enable;
    logic          mc_cmd;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wr_data;
    logic          mc_data_rdy = 1'b0;
    logic [DW-1:0] mc_rd_data = '0;
    logic          mc_rd_data_valid = 1'b0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [2:0]    fifo_count;
    logic          busy;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_issue = 0;
    int n_rsp   = 0;
    int base_issue;
    int base_rsp;
    logic [AW-1:0] iss_addr [$];
    logic [DW-1:0] iss_data [$];

    mctrl_req_queue #(
        .ADDR_MCTRL(27), .DQ_BITS(8), .DEPTH(4), .TIMEOUT(64)
    ) dut (
        .i_cpu_ck(clk), .i_cpu_reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .mc_valid(mc_valid), .mc_enable(mc_enable), .mc_cmd(mc_cmd),
        .mc_addr(mc_addr), .mc_wr_data(mc_wr_data),
        .mc_data_rdy(mc_data_rdy), .mc_rd_data(mc_rd_data),
        .mc_rd_data_valid(mc_rd_data_valid),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Log every issue pulse and response pulse mid-cycle.
    always @(negedge clk) begin
        if (mc_valid) begin
            n_issue++;
            iss_addr.push_back(mc_addr);
            iss_data.push_back(mc_wr_data);
        end
        if (rsp_valid) n_rsp++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        check("rst_mc_valid",  64'(mc_valid), 64'd0);
        check("rst_mc_enable", 64'(mc_enable), 64'd0);
        check("rst_count",     64'(fifo_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_timeout",   64'(timeout_err), 64'd0);
        rst = 1'b0;
        check("enable_before_edge", 64'(mc_enable), 64'd0);
        tick;
        check("enable_after_edge", 64'(mc_enable), 64'd1);

        // Single write
        mc_data_rdy = 1'b1;
        req_valid = 1'b1; req_cmd = 1'b1;
        req_addr = 27'h0000123; req_wr_data = 64'h0123456789ABCDEF;
        tick;
        req_valid = 1'b0;
        check("wr_count_push", 64'(fifo_count), 64'd1);
        check("wr_no_valid_yet", 64'(mc_valid), 64'd0);
        tick;
        check("wr_mc_valid", 64'(mc_valid), 64'd1);
        check("wr_mc_cmd",   64'(mc_cmd), 64'd1);
        check("wr_mc_addr",  64'(mc_addr), 64'h123);
        check("wr_mc_data",  mc_wr_data, 64'h0123456789ABCDEF);
        check("wr_busy_issue", 64'(busy), 64'd1);
        check("wr_count_pop", 64'(fifo_count), 64'd0);
        tick;
        check("wr_valid_one_cycle", 64'(mc_valid), 64'd0);
        check("wr_busy_hold", 64'(busy), 64'd1);
        tick;
        check("wr_busy_fall", 64'(busy), 64'd0);
        check("wr_issue_count", 64'(n_issue), 64'd1);

        // Single read with response 10 cycles after issue
        req_valid = 1'b1; req_cmd = 1'b0;
        req_addr = 27'h0000040; req_wr_data = '0;
        tick;
        req_valid = 1'b0;
        tick;
        check("rd_mc_valid", 64'(mc_valid), 64'd1);
        check("rd_mc_cmd",   64'(mc_cmd), 64'd0);
        check("rd_mc_addr",  64'(mc_addr), 64'h40);
        repeat (9) tick;
        check("rd_no_rsp_early", 64'(rsp_valid), 64'd0);
        check("rd_busy_wait", 64'(busy), 64'd1);
        mc_rd_data_valid = 1'b1; mc_rd_data = 64'hDEADBEEFCAFEF00D;
        tick;
        mc_rd_data_valid = 1'b0;
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_addr",  64'(rsp_addr), 64'h40);
        check("rd_rsp_data",  rsp_data, 64'hDEADBEEFCAFEF00D);
        check("rd_busy_fall", 64'(busy), 64'd0);
        tick;
        check("rd_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        // Stray read data while idle is ignored
        mc_rd_data_valid = 1'b1; mc_rd_data = 64'h5555;
        tick;
        mc_rd_data_valid = 1'b0;
        check("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        check("stray_rsp_data",  rsp_data, 64'hDEADBEEFCAFEF00D);
        check("rd_rsp_count", 64'(n_rsp), 64'd1);

        // Full FIFO: five writes with the controller not ready
        mc_data_rdy = 1'b0;
        iss_addr.delete(); iss_data.delete();
        base_issue = n_issue;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_cmd = 1'b1;
            req_addr = AW'(32'h100 + 32'(i));
            req_wr_data = DW'(64'hA0 + 64'(i));
            tick;
        end
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(req_ready), 64'd0);
        check("full_no_issue", 64'(n_issue - base_issue), 64'd0);
        mc_data_rdy = 1'b1;
        tick;
        check("full_pop_count", 64'(fifo_count), 64'd3);
        check("full_pop_ready", 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0;
        check("full_fifth_push", 64'(fifo_count), 64'd4);
        for (int k = 0; k < 60 && !(busy == 1'b0 && fifo_count == 3'd0); k++) tick;
        check("full_drained_busy", 64'(busy), 64'd0);
        check("full_drained_count", 64'(fifo_count), 64'd0);
        check("full_issue_total", 64'(iss_addr.size()), 64'd5);
        for (int i = 0; i < 5 && i < iss_addr.size(); i++) begin
            check("full_order_addr", 64'(iss_addr[i]), 64'h100 + 64'(i));
            check("full_order_data", iss_data[i], 64'hA0 + 64'(i));
        end

        // Read timeout, then a queued write still issues
        base_rsp = n_rsp;
        req_valid = 1'b1; req_cmd = 1'b0; req_addr = 27'h0000200; req_wr_data = '0;
        tick;
        req_cmd = 1'b1; req_addr = 27'h0000300; req_wr_data = 64'h3333;
        tick;
        req_valid = 1'b0;
        check("to_rd_issue", 64'(mc_valid), 64'd1);
        check("to_queued", 64'(fifo_count), 64'd1);
        tick;
        repeat (63) tick;
        check("to_not_yet", 64'(timeout_err), 64'd0);
        check("to_still_busy", 64'(busy), 64'd1);
        tick;
        check("to_flag", 64'(timeout_err), 64'd1);
        check("to_busy_fall", 64'(busy), 64'd0);
        tick;
        check("to_next_valid", 64'(mc_valid), 64'd1);
        check("to_next_cmd",   64'(mc_cmd), 64'd1);
        check("to_next_addr",  64'(mc_addr), 64'h300);
        repeat (3) tick;
        check("to_no_rsp", 64'(n_rsp - base_rsp), 64'd0);
        check("to_sticky", 64'(timeout_err), 64'd1);

        // Reset asserted mid-cycle while a read waits and two entries are queued
        req_valid = 1'b1; req_cmd = 1'b0; req_addr = 27'h0000400; req_wr_data = '0;
        tick;
        req_cmd = 1'b1; req_addr = 27'h0000500; req_wr_data = 64'h5;
        tick;
        req_addr = 27'h0000600; req_wr_data = 64'h6;
        tick;
        req_valid = 1'b0;
        tick;
        check("wrst_queued", 64'(fifo_count), 64'd2);
        check("wrst_waiting", 64'(busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("wrst_count",     64'(fifo_count), 64'd0);
        check("wrst_busy",      64'(busy), 64'd0);
        check("wrst_mc_valid",  64'(mc_valid), 64'd0);
        check("wrst_mc_enable", 64'(mc_enable), 64'd0);
        check("wrst_mc_addr",   64'(mc_addr), 64'd0);
        check("wrst_mc_cmd",    64'(mc_cmd), 64'd0);
        check("wrst_rsp_data",  rsp_data, 64'd0);
        check("wrst_timeout",   64'(timeout_err), 64'd0);
        check("wrst_ready",     64'(req_ready), 64'd1);
        base_issue = n_issue;
        base_rsp   = n_rsp;
        tick;
        rst = 1'b0;
        mc_rd_data_valid = 1'b1; mc_rd_data = 64'h77;
        tick;
        mc_rd_data_valid = 1'b0;
        check("wrst_enable_back", 64'(mc_enable), 64'd1);
        repeat (20) tick;
        check("wrst_no_issue", 64'(n_issue - base_issue), 64'd0);
        check("wrst_no_rsp",   64'(n_rsp - base_rsp), 64'd0);
        check("wrst_idle",     64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
